// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting in front of a byte-addressed,
// combinational-read instruction memory. Owns the PC, captures each fetched
// word into an IF/ID register and offers it to decode over valid/ready.
// Supports stall, redirect with flush, and a halt at the end of the image.
//
// Optional build macro: FETCH_COUNT_EN adds a 32-bit fetch_count output that
// counts completed IF/ID transfers (flushed words are not counted).
`timescale 1ns/1ps

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        fault
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  // Size of the image and the highest address a word can be fetched from.
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [31:0] LAST_PC    = 32'(IMEM_BYTES) - 32'd4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,  // one settle cycle after reset release, no fetch
    ST_RUN  = 2'd1,  // fetching one word per accepted cycle
    ST_HALT = 2'd2   // end of image or bad redirect; waits for a good redirect
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] id_pc_q;
  logic        halted_q;
  logic        fault_q;

  logic        target_ok_s;
  logic        accept_s;
  logic        transfer_s;

  // A redirect is only honoured when it lands on a word inside the image.
  assign target_ok_s = (redirect_pc[1:0] == 2'b00) && (redirect_pc < IMEM_LIMIT);
  // The IF/ID register can take a new word when it is empty or being drained.
  assign accept_s    = (!valid_q) || id_ready;
  // Decode consumes the held word this cycle.
  assign transfer_s  = valid_q && id_ready;

  // Fetch FSM: PC, IF/ID register and status flags, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_WAIT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      id_pc_q  <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // fault is a single-cycle pulse unless re-armed below
      fault_q <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
        ST_RUN: begin
          if (redirect_valid && target_ok_s) begin
            // Taken branch: retarget and drop whatever IF/ID holds.
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
          end else if (redirect_valid) begin
            // Unusable target: flag it, flush, and stop fetching.
            fault_q  <= 1'b1;
            valid_q  <= 1'b0;
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (accept_s) begin
            instr_q <= instruction_code;
            id_pc_q <= pc_q;
            valid_q <= 1'b1;
            if (pc_q == LAST_PC) begin
              // Last word of the image is still delivered; PC parks here.
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end else begin
            // Decode stalled: everything holds.
            valid_q <= valid_q;
          end
        end
        ST_HALT: begin
          if (redirect_valid && target_ok_s) begin
            pc_q     <= redirect_pc;
            valid_q  <= 1'b0;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (redirect_valid) begin
            fault_q <= 1'b1;
            valid_q <= 1'b0;
          end else if (transfer_s) begin
            // Final pending word consumed; nothing more to offer.
            valid_q <= 1'b0;
          end else begin
            valid_q <= valid_q;
          end
        end
        default: begin
          state_q  <= ST_WAIT;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign id_valid = valid_q;
  assign id_instr = instr_q;
  assign id_pc    = id_pc_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;

  // Completed-transfer counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (transfer_s) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign fetch_count = count_q;
`endif

  fetch_stage_checker #(
    .LAST_PC (LAST_PC)
  ) u_checker (
    .clk_i            (clk),
    .reset_i          (reset),
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .id_ready_i       (id_ready),
    .id_valid_i       (valid_q),
    .id_instr_i       (instr_q),
    .id_pc_i          (id_pc_q),
    .halted_i         (halted_q),
    .fault_i          (fault_q)
  );

endmodule

// Structural invariants of the fetch stage, kept apart from the datapath.
module fetch_stage_checker #(
  parameter logic [31:0] LAST_PC = 32'd28
) (
  input logic        clk_i,
  input logic        reset_i,
  input logic [31:0] pc_i,
  input logic        redirect_valid_i,
  input logic        id_ready_i,
  input logic        id_valid_i,
  input logic [31:0] id_instr_i,
  input logic [31:0] id_pc_i,
  input logic        halted_i,
  input logic        fault_i
);

  // The PC always points at a whole word inside the image.
  a_pc_aligned: assert property (@(posedge clk_i) disable iff (!reset_i)
    pc_i[1:0] == 2'b00);

  a_pc_in_range: assert property (@(posedge clk_i) disable iff (!reset_i)
    pc_i <= LAST_PC);

  // A fault is only ever raised together with entry into (or stay in) HALT.
  a_fault_halts: assert property (@(posedge clk_i) disable iff (!reset_i)
    fault_i |-> halted_i);

  // A stalled word without a redirect stays put, bit for bit.
  a_stall_hold: assert property (@(posedge clk_i) disable iff (!reset_i)
    (id_valid_i && !id_ready_i && !redirect_valid_i)
      |=> (id_valid_i && $stable(id_instr_i) && $stable(id_pc_i)));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage. A rule-level reference model
// predicts each cycle's outputs; expected IF/ID transfers are queued by the
// driver and popped by an independent monitor on every DUT handshake.
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam int unsigned IMEM_BYTES = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        fault;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .instruction_code (instruction_code),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .halted           (halted),
    .fault            (fault)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count      (fetch_count)
`endif
  );

  // Instruction image and combinational memory read.
  logic [31:0] img [0:7];
  initial begin
    img[0] = 32'h0094_0333; img[1] = 32'h4139_03b3;
    img[2] = 32'h035a_02b3; img[3] = 32'h0000_0013;
    img[4] = 32'h019c_1eb3; img[5] = 32'h00a0_0093;
    img[6] = 32'h4020_8133; img[7] = 32'h00f7_68b3;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(IMEM_BYTES)) return img[a[4:2]];
    else                     return 32'h0;
  endfunction

  assign instruction_code = mem_word(pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard.
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q [$];
  logic        mon_en   = 1'b0;

  // Reference model state (value held after the most recent clock edge).
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halt, m_fault, m_wait;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RESET_PC; m_instr = 32'd0; m_ipc = 32'd0; m_count = 32'd0;
    m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_wait = 1'b1;
  endtask

  // One clock cycle: apply inputs, predict, advance, commit prediction.
  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] n_pc, n_instr, n_ipc, n_count;
    logic        n_valid, n_halt, n_fault, n_wait, good;
    id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_count = m_count;
    n_valid = m_valid; n_halt = m_halt; n_fault = 1'b0; n_wait = m_wait;
    good = ((rpc % 32'd4) == 32'd0) && (rpc < 32'(IMEM_BYTES));
    if (reset && m_valid && rdy) begin
      exp_q.push_back({m_instr, m_ipc});
      n_count = m_count + 32'd1;
    end
    if (m_wait) begin
      n_wait = 1'b0;
    end else if (rv && good) begin
      n_pc = rpc; n_valid = 1'b0; n_halt = 1'b0;
    end else if (rv) begin
      n_fault = 1'b1; n_valid = 1'b0; n_halt = 1'b1;
    end else if (m_halt) begin
      if (m_valid && rdy) n_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      n_instr = mem_word(m_pc); n_ipc = m_pc; n_valid = 1'b1;
      if (m_pc == 32'(IMEM_BYTES) - 32'd4) n_halt = 1'b1;
      else                                 n_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    if (!reset) begin
      m_reset();
    end else begin
      m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_count = n_count;
      m_valid = n_valid; m_halt = n_halt; m_fault = n_fault; m_wait = n_wait;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk32({tag, "_pc"}, pc, RESET_PC);
    chk1({tag, "_id_valid"}, id_valid, 1'b0);
    chk32({tag, "_id_instr"}, id_instr, 32'd0);
    chk32({tag, "_id_pc"}, id_pc, 32'd0);
    chk1({tag, "_halted"}, halted, 1'b0);
    chk1({tag, "_fault"}, fault, 1'b0);
`ifdef FETCH_COUNT_EN
    chk32({tag, "_fetch_count"}, fetch_count, 32'd0);
`endif
  endtask

  // Reset asserted between edges while the current inputs stay applied.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    m_reset();
    exp_q.delete();
    #1;
    check_reset_outputs(tag);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor: status vs model every cycle, transfers vs scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] e;
      chk32("mon_pc", pc, m_pc);
      chk1("mon_id_valid", id_valid, m_valid);
      chk1("mon_halted", halted, m_halt);
      chk1("mon_fault", fault, m_fault);
`ifdef FETCH_COUNT_EN
      chk32("mon_fetch_count", fetch_count, m_count);
`endif
      if (m_valid) begin
        chk32("mon_hold_instr", id_instr, m_instr);
        chk32("mon_hold_pc", id_pc, m_ipc);
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got pc %h instr %h expected no transfer", id_pc, id_instr);
        end else begin
          e = exp_q.pop_front();
          chk32("xfer_instr", id_instr, e[63:32]);
          chk32("xfer_pc", id_pc, e[31:0]);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // WAIT cycle: no fetch yet.
    cycle(1'b1, 1'b0, 32'd0);
    chk1("wait_no_valid", id_valid, 1'b0);
    // Sequential fetch.
    cycle(1'b1, 1'b0, 32'd0);
    chk32("seq0_instr", id_instr, 32'h0094_0333); chk32("seq0_pc", id_pc, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk32("seq1_instr", id_instr, 32'h4139_03b3); chk32("seq1_pc", id_pc, 32'd4);
    // Stall for three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      chk32("stall_instr", id_instr, 32'h4139_03b3);
      chk32("stall_idpc", id_pc, 32'd4);
      chk32("stall_pc", pc, 32'd8);
    end
    cycle(1'b1, 1'b0, 32'd0);
    chk32("seq2_instr", id_instr, 32'h035a_02b3); chk32("seq2_pc", id_pc, 32'd8);
    // Redirect while decode is stalled.
    cycle(1'b0, 1'b1, 32'd16);
    chk1("redir_flush", id_valid, 1'b0); chk32("redir_pc", pc, 32'd16);
    cycle(1'b1, 1'b0, 32'd0);
    chk32("redir_instr", id_instr, 32'h019c_1eb3); chk32("redir_idpc", id_pc, 32'd16);
    // Run to end of image.
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk32("end_instr", id_instr, 32'h00f7_68b3); chk32("end_idpc", id_pc, 32'd28);
    chk1("end_halted", halted, 1'b1); chk32("end_pc", pc, 32'd28);
    cycle(1'b1, 1'b0, 32'd0);
    chk1("end_drained", id_valid, 1'b0); chk32("end_pc_hold", pc, 32'd28);
    // Bad redirects: back into RUN first, then misaligned and out of range.
    cycle(1'b0, 1'b1, 32'd0);
    chk1("rerun_halted", halted, 1'b0);
    cycle(1'b0, 1'b1, 32'h6);
    chk1("bad6_fault", fault, 1'b1); chk1("bad6_halted", halted, 1'b1);
    chk1("bad6_valid", id_valid, 1'b0); chk32("bad6_pc", pc, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk1("bad6_pulse", fault, 1'b0);
    cycle(1'b1, 1'b1, 32'h40);
    chk1("bad40_fault", fault, 1'b1); chk1("bad40_halted", halted, 1'b1);
    cycle(1'b1, 1'b0, 32'd0);
    chk1("bad40_pulse", fault, 1'b0);
    cycle(1'b1, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk32("recover_instr", id_instr, 32'h0094_0333); chk1("recover_valid", id_valid, 1'b1);
    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    async_reset("arst");
    cycle(1'b1, 1'b0, 32'd0);
    chk1("arst_wait", id_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'd0);
    chk32("arst_first", id_instr, 32'h0094_0333); chk32("arst_first_pc", id_pc, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        rdy, rv;
      logic [31:0] tgt;
      int unsigned kind;
      rdy  = ($urandom_range(0, 9) < 7);
      rv   = ($urandom_range(0, 99) < 6);
      kind = $urandom_range(0, 9);
      if (kind < 7)       tgt = 32'($urandom_range(0, 7)) << 2;
      else if (kind == 7) tgt = (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
      else if (kind == 8) tgt = 32'(IMEM_BYTES) + (32'($urandom_range(0, 15)) << 2);
      else                tgt = $urandom;
      if ($urandom_range(0, 999) < 3) async_reset("rnd_arst");
      else                            cycle(rdy, rv, tgt);
    end
    cycle(1'b0, 1'b0, 32'd0);
    chk32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
